// File: rtl/apu_uart_loader.sv
// apu_uart_loader: 8N1 serial receiver that pairs address/data bytes into single-cycle APU
// register writes and drives the `link` activity output. Define UART_PARITY_EN for 8E1 frames.
module apu_uart_loader #(
    parameter int unsigned OSCRATE      = 12_000_000,
    parameter int unsigned BAUDRATE     = 9600,
    parameter int unsigned TIMEOUT_BITS = 20,
    parameter int unsigned LINK_CYC     = OSCRATE / 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    output logic       link
);

    localparam int unsigned BIT_CYC = OSCRATE / BAUDRATE;
    localparam int unsigned TMO_CYC = TIMEOUT_BITS * BIT_CYC;
    localparam int unsigned BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned TW      = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam int unsigned LW      = (LINK_CYC > 0) ? $clog2(LINK_CYC + 1) : 1;

    localparam logic [BW-1:0] HALF_LOAD = BW'(BIT_CYC / 2 - 1);
    localparam logic [BW-1:0] FULL_LOAD = BW'(BIT_CYC - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_CYC);
    localparam logic [LW-1:0] LINK_LOAD = LW'(LINK_CYC);

    localparam logic [2:0] R_IDLE  = 3'd0;
    localparam logic [2:0] R_START = 3'd1;
    localparam logic [2:0] R_DATA  = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] R_PAR   = 3'd3;
`endif
    localparam logic [2:0] R_STOP  = 3'd4;

    localparam logic F_ADDR = 1'b0;
    localparam logic F_DATA = 1'b1;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic rx_meta_q, rxs_q, rxs_prev_q;

    // Reset to low so a line held low across reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b0;
            rxs_q      <= 1'b0;
            rxs_prev_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ------------------------------------------------------------------
    // Bit receiver
    // ------------------------------------------------------------------
    logic [2:0]    rstate_q, rstate_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
`ifdef UART_PARITY_EN
    logic          par_err_q, par_err_d;
`endif
    logic          bit_tick;
    logic          start_edge;
    logic          byte_ok;
    logic          byte_bad;

    assign bit_tick = (bit_cnt_q == '0);

    always_comb begin
        rstate_d   = rstate_q;
        bit_cnt_d  = bit_tick ? bit_cnt_q : bit_cnt_q - BW'(1);
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
`ifdef UART_PARITY_EN
        par_err_d  = par_err_q;
`endif
        start_edge = 1'b0;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    start_edge = 1'b1;
                    rstate_d   = R_START;
                    bit_cnt_d  = HALF_LOAD;
                end
            end
            R_START: begin
                if (bit_tick) begin
                    if (!rxs_q) begin
                        rstate_d  = R_DATA;
                        bit_cnt_d = FULL_LOAD;
                        bit_idx_d = 3'd0;
                    end else begin
                        rstate_d = R_IDLE;
                    end
                end
            end
            R_DATA: begin
                if (bit_tick) begin
                    shreg_d   = {rxs_q, shreg_q[7:1]};
                    bit_cnt_d = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        rstate_d = R_PAR;
`else
                        rstate_d = R_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PAR: begin
                if (bit_tick) begin
                    par_err_d = (rxs_q != ^shreg_q);
                    bit_cnt_d = FULL_LOAD;
                    rstate_d  = R_STOP;
                end
            end
`endif
            R_STOP: begin
                // Return to idle at the stop-bit centre so a back-to-back start edge is caught.
                if (bit_tick) begin
                    rstate_d = R_IDLE;
`ifdef UART_PARITY_EN
                    if (rxs_q && !par_err_q) byte_ok = 1'b1;
                    else                     byte_bad = 1'b1;
`else
                    if (rxs_q) byte_ok = 1'b1;
                    else       byte_bad = 1'b1;
`endif
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q  <= R_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'd0;
`ifdef UART_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rstate_q  <= rstate_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
`ifdef UART_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Frame assembler, timeout and link
    // ------------------------------------------------------------------
    logic          fstate_q, fstate_d;
    logic [4:0]    addr_q, addr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [LW-1:0] link_cnt_q, link_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        fstate_d    = fstate_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        link_cnt_d  = (link_cnt_q != '0) ? link_cnt_q - LW'(1) : link_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        // Timeout only advances while the line is idle between bytes of a frame.
        if (fstate_q != F_DATA || start_edge) begin
            tmo_d = '0;
        end else if (rstate_q == R_IDLE && tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end

        if (byte_bad) begin
            frame_err_d = 1'b1;
            fstate_d    = F_ADDR;
        end else if (byte_ok) begin
            link_cnt_d = LINK_LOAD;
            if (fstate_q == F_ADDR) begin
                if (shreg_q[7:5] == 3'b000 && shreg_q[4:0] <= 5'd23) begin
                    addr_d   = shreg_q[4:0];
                    fstate_d = F_DATA;
                    tmo_d    = '0;
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = shreg_q;
                fstate_d  = F_ADDR;
            end
        end else if (fstate_q == F_DATA && tmo_q == TMO_MAX) begin
            fstate_d = F_ADDR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q    <= F_ADDR;
            addr_q      <= 5'd0;
            tmo_q       <= '0;
            link_cnt_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 8'd0;
            frame_err_q <= 1'b0;
        end else begin
            fstate_q    <= fstate_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            link_cnt_q  <= link_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;
    assign link      = (link_cnt_q != '0);

endmodule

// File: tb/tb_apu_uart_loader.sv
// Scoreboard bench for apu_uart_loader: directed frames plus random byte streams checked
// against a byte-level model of the address/data pairing rules.
`timescale 1ns/1ps
module tb_apu_uart_loader;

    localparam int unsigned OSC      = 160_000;
    localparam int unsigned BAUD     = 10_000;
    localparam int unsigned TMO_BITS = 20;
    localparam int unsigned LINK     = 600;
    localparam int          B        = OSC / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic       link;

    always #5 clk = ~clk;

    apu_uart_loader #(
        .OSCRATE     (OSC),
        .BAUDRATE    (BAUD),
        .TIMEOUT_BITS(TMO_BITS),
        .LINK_CYC    (LINK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .link     (link)
    );

    typedef struct packed {
        bit         is_wr;
        logic [4:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         pending = 1'b0;
    logic [4:0] paddr = 5'd0;
    bit         prev_bad = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the next expected event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (wr_en || frame_err)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: wr_en=%0b frame_err=%0b addr=%0d data=%0h, required no event",
                         wr_en, frame_err, wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("event_wr_en", int'(wr_en), int'(e.is_wr));
                check("event_frame_err", int'(frame_err), int'(!e.is_wr));
                if (e.is_wr) begin
                    check("wr_addr", int'(wr_addr), int'(e.a));
                    check("wr_data", int'(wr_data), int'(e.d));
                end
            end
        end
    end

    // Model the byte's effect, then drive it on the line after idle_bits of idle.
    task automatic send_byte(input logic [7:0] v, input bit stop_ok, input bit par_ok,
                             input int idle_bits);
        ev_t e;
        int  idle;
        idle = idle_bits;
        if (prev_bad && idle == 0) idle = 1;
        if (idle >= int'(TMO_BITS)) pending = 1'b0;
        e = '0;
        if (!stop_ok || !par_ok) begin
            exp_q.push_back(e);
            pending = 1'b0;
        end else if (!pending) begin
            if (v <= 8'd23) begin
                pending = 1'b1;
                paddr   = v[4:0];
            end else begin
                exp_q.push_back(e);
            end
        end else begin
            e.is_wr = 1'b1;
            e.a     = paddr;
            e.d     = v;
            exp_q.push_back(e);
            pending = 1'b0;
        end
        prev_bad = !stop_ok;

        if (idle > 0) wait_cyc(idle * B);
        rx = 1'b0;
        wait_cyc(B);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            wait_cyc(B);
        end
`ifdef UART_PARITY_EN
        rx = (^v) ^ !par_ok;
        wait_cyc(B);
`endif
        rx = stop_ok;
        wait_cyc(B);
        rx = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_link"}, int'(link), 0);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        pending = 1'b0;
        wait_cyc(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        wait_cyc(4);
        check_outputs_zero("por");
        rst_n = 1'b1;
        wait_cyc(3 * B);

        // Basic write
        send_byte(8'h15, 1'b1, 1'b1, 1);
        send_byte(8'hA7, 1'b1, 1'b1, 0);
        // Bad address, then the next byte is also treated as an address
        send_byte(8'h18, 1'b1, 1'b1, 2);
        send_byte(8'h55, 1'b1, 1'b1, 0);
        // Framing error on the data byte, then a clean retry
        send_byte(8'h03, 1'b1, 1'b1, 2);
        send_byte(8'h42, 1'b0, 1'b1, 0);
        send_byte(8'h03, 1'b1, 1'b1, 1);
        send_byte(8'h42, 1'b1, 1'b1, 0);
        // Timeout abandons the address byte
        send_byte(8'h00, 1'b1, 1'b1, 2);
        send_byte(8'h01, 1'b1, 1'b1, 21);
        send_byte(8'h7F, 1'b1, 1'b1, 0);

        // Link holds for LINK clocks after the last valid byte
        wait_cyc(int'(LINK) - 20);
        check("link_held", int'(link), 1);
        wait_cyc(40);
        check("link_expired", int'(link), 0);

        // Short glitch shorter than half a bit
        rx = 1'b0;
        wait_cyc(B / 2 - 2);
        rx = 1'b1;
        wait_cyc(4 * B);
        check("glitch_link", int'(link), 0);

        // Reset in the middle of a data byte, with an address already latched
        send_byte(8'h09, 1'b1, 1'b1, 2);
        wait_cyc(B);
        rx = 1'b0;
        wait_cyc(B);
        rx = 1'b1;
        wait_cyc(B);
        rx = 1'b0;
        wait_cyc(B / 2);
        do_reset();
        // Line still low after reset release must not start a byte
        wait_cyc(2 * B);
        rx = 1'b1;
        wait_cyc(12 * B);
        send_byte(8'h07, 1'b1, 1'b1, 1);
        send_byte(8'h3C, 1'b1, 1'b1, 0);

`ifdef UART_PARITY_EN
        send_byte(8'h05, 1'b1, 1'b1, 1);
        send_byte(8'h99, 1'b1, 1'b0, 0);
        send_byte(8'h05, 1'b1, 1'b1, 1);
        send_byte(8'h99, 1'b1, 1'b1, 0);
`endif

        // Random stream
        for (int i = 0; i < 30; i++) begin
            logic [7:0] v;
            bit         sok;
            bit         pok;
            int         idl;
            v   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 23))
                                              : 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 9) != 0);
            pok = 1'b1;
`ifdef UART_PARITY_EN
            pok = ($urandom_range(0, 9) != 0);
`endif
            idl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(22, 26))
                                              : int'($urandom_range(0, 4));
            send_byte(v, sok, pok, idl);
        end

        wait_cyc(4 * B);
        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apu_uart_loader.md
# apu_uart_loader

Serial register loader that sits directly upstream of the APU core. It receives 8N1 bytes on the host RX line (ui_in[2]) at BAUDRATE and pairs them into address/data frames. Each complete frame becomes a single-cycle register write strobe into the APU register file. It also drives the RX activity status output (uo_out[4], `link`).

## Interface
Parameters:
- OSCRATE, 12_000_000: system clock frequency in Hz.
- BAUDRATE, 9600: serial bit rate. Bit period BIT_CYC = OSCRATE/BAUDRATE (1250 at defaults).
- TIMEOUT_BITS, 20: idle bit periods after an address byte before the frame is abandoned.
- LINK_CYC, OSCRATE/20: `link` hold time in clocks after each accepted byte (50 ms at defaults).

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset. Asynchronous and active-low.
- rx, input, 1: asynchronous serial input, idle high.
- wr_en, output, 1: one-cycle write strobe.
- wr_addr, output, 5: APU register index, 0..23 (maps to $4000–$4017).
- wr_data, output, 8: APU register data.
- frame_err, output, 1: one-cycle pulse on a framing, parity or address error.
- link, output, 1: RX activity status.

## Operation
- **RX synchronizer:** rx passes through a 2-FF synchronizer; all logic uses the synchronized value `rxs`.
- **Bit receiver FSM** (R_IDLE, R_START, R_DATA, R_PAR, R_STOP):
  - R_IDLE: a falling edge on `rxs` moves to R_START and loads the bit counter with BIT_CYC/2−1.
  - R_START: at count expiry, `rxs`=0 moves to R_DATA. `rxs`=1 is a glitch: return to R_IDLE with no error.
  - R_DATA: 8 bits sampled LSB first, one every BIT_CYC clocks, at bit centre.
  - R_PAR: present only with UART_PARITY_EN.
  - R_STOP: stop bit sampled at bit centre. `rxs`=1 means the byte is valid. `rxs`=0 pulses frame_err and discards the byte.
  - After R_STOP, the FSM returns to R_IDLE immediately; no wait for the rest of the stop bit.
- **Frame FSM** (F_ADDR, F_DATA):
  - F_ADDR, valid byte b:
    - b[7:5]=000 and b[4:0]≤23: latch the address and go to F_DATA.
    - Otherwise: pulse frame_err and stay in F_ADDR.
  - F_DATA, valid byte: present the latched address on wr_addr and the byte on wr_data, pulse wr_en, return to F_ADDR.
  - F_DATA timeout: the timeout counter restarts at each byte. If TIMEOUT_BITS×BIT_CYC clocks pass with no start edge, return to F_ADDR silently.
  - Any framing or parity error (frame_err) forces the frame FSM to F_ADDR.
- **Link:**
  - Every valid byte (address, data, or rejected address with good framing) reloads the link counter to LINK_CYC.
  - link = (counter≠0). The counter decrements to 0 and saturates there.
- **Counter widths:** every counter is sized with $clog2 of its maximum value. Nothing wraps.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_err=0, link=0. Both FSMs in their idle/ADDR state; all counters 0.
- Reset mid-byte or mid-frame: the partial byte and any latched address are discarded. Reception resumes only on a fresh falling edge after rst_n deasserts.
- Latency: wr_en and frame_err assert on the clock after the stop-bit sample, i.e. 2 (synchronizer) + BIT_CYC/2 + 9×BIT_CYC clocks after the rx falling edge. Without parity this is 11877 clocks at defaults.
- Registered outputs: wr_en and frame_err are high for exactly one clock. wr_addr and wr_data are registered and stable from the wr_en cycle until the next write.
- Back-to-back frames at full line rate are supported. A start edge arriving during the stop-bit remainder is accepted.

## Configuration
- UART_PARITY_EN:
  - Defined: the frame is 8E1. The R_PAR state samples a parity bit after bit 7, and the stop bit is sampled one BIT_CYC later.
  - Parity mismatch: frame_err pulses, the byte is discarded and the frame FSM returns to F_ADDR.
  - Not defined: 8N1 with no R_PAR state, and all latencies are as stated above.

## Test plan
- **Basic write:** send 0x15 then 0xA7 at 9600 baud → one wr_en pulse with wr_addr=0x15, wr_data=0xA7; frame_err never asserts.
- **Bad address:** send 0x18 then 0x55 → frame_err pulses after 0x18; 0x55 is taken as an address byte, so frame_err pulses again; no wr_en.
- **Framing error:** send 0x03, then 0x42 with a low stop bit → frame_err pulses, no wr_en. Then 0x03, 0x42 → write to addr 3 with data 0x42.
- **Timeout:** send 0x00, idle 21 bit periods, then 0x01, 0x7F → single write with addr 1, data 0x7F.
- **Glitch and reset:** a 300-clock low pulse on rx → no activity and link stays 0. Assert rst_n mid-data-byte → all outputs 0, and the next full frame writes correctly.
- **Link and parity:** link is high for LINK_CYC clocks after the last valid byte, then falls to 0. With UART_PARITY_EN, a bad-parity data byte gives frame_err and no wr_en.
